// File: rtl/id_stage_reg_pkg.sv
// Shared decode types for the ID stage: opcodes, ALU encodings and the
// registered control bundle handed from decode to EX.
package id_stage_reg_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int ALU_SRC_W = 2;
    localparam int RF_W      = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [ALU_SRC_W-1:0] {
        ALU_SRC_REG    = 2'd0,
        ALU_SRC_IMM    = 2'd1,
        ALU_SRC_IMM_PC = 2'd2,
        ALU_SRC_FOR_PC = 2'd3
    } alu_src_e;

    localparam logic [6:0] INST_TYPE_R = 7'h33;
    localparam logic [6:0] INST_TYPE_I = 7'h13;
    localparam logic [6:0] INST_LOAD   = 7'h03;
    localparam logic [6:0] INST_STORE  = 7'h23;
    localparam logic [6:0] INST_BRANCH = 7'h63;
    localparam logic [6:0] INST_JAL    = 7'h6f;
    localparam logic [6:0] INST_JALR   = 7'h67;
    localparam logic [6:0] INST_LUI    = 7'h37;
    localparam logic [6:0] INST_AUIPC  = 7'h17;

    typedef struct packed {
        logic            reg_wen;
        logic [RF_W-1:0] rd;
        logic [RF_W-1:0] rs1;
        logic [RF_W-1:0] rs2;
        alu_op_e         alu_op;
        alu_src_e        alu_src;
        logic [2:0]      branch_op;
        logic            jump;
        logic            jalr;
        logic            mem_rd;
        logic            mem_wr;
        logic [2:0]      mem_size;
        logic            illegal;
    } ctrl_t;

    function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_reg_decode.sv
// Pure combinational RV32I decoder: instruction word to control bundle,
// immediate and source-register usage flags.
import id_stage_reg_pkg::*;

module id_decode_comb #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            rs1_used,
    output logic            rs2_used
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       rd_used;
    logic       sh_zero;
    logic       sh_alt;
    logic signed [31:0] u32;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];
    assign u32 = {ir[31:12], 12'h000};

    assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = XLEN'(u32);
    assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // RV64 shifts take a 6-bit shamt, so one fewer funct bit is checked
    assign sh_zero = (XLEN == 64) ? (ir[31:26] == 6'h00) : (f7 == 7'h00);
    assign sh_alt  = (XLEN == 64) ? (ir[31:26] == 6'h10) : (f7 == 7'h20);

    always_comb begin
        ctrl     = '0;
        imm      = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        unique case (1'b1)
            opc == INST_TYPE_R: begin
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                rd_used      = 1'b1;
                ctrl.alu_op  = alu_dec(f3, f7[5]);
                ctrl.illegal = !(f7 == 7'h00 ||
                                 (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            opc == INST_TYPE_I: begin
                rs1_used     = 1'b1;
                rd_used      = 1'b1;
                imm          = imm_i;
                ctrl.alu_src = ALU_SRC_IMM;
                ctrl.alu_op  = alu_dec(f3, f3 == 3'd5 && sh_alt);
                ctrl.illegal = (f3 == 3'd1 && !sh_zero) ||
                               (f3 == 3'd5 && !(sh_zero || sh_alt));
            end
            opc == INST_LOAD: begin
                rs1_used      = 1'b1;
                rd_used       = 1'b1;
                imm           = imm_i;
                ctrl.mem_rd   = 1'b1;
                ctrl.mem_size = f3;
                ctrl.alu_op   = ALU_ADD;
                ctrl.alu_src  = ALU_SRC_IMM;
                ctrl.illegal  = f3 inside {3'd3, 3'd6, 3'd7};
            end
            opc == INST_STORE: begin
                rs1_used      = 1'b1;
                rs2_used      = 1'b1;
                imm           = imm_s;
                ctrl.mem_wr   = 1'b1;
                ctrl.mem_size = f3;
                ctrl.alu_op   = ALU_ADD;
                ctrl.alu_src  = ALU_SRC_IMM;
                ctrl.illegal  = f3 > 3'd2;
            end
            opc == INST_BRANCH: begin
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                imm            = imm_b;
                ctrl.branch_op = f3;
                ctrl.alu_op    = ALU_SUB;
                ctrl.alu_src   = ALU_SRC_REG;
                ctrl.illegal   = f3 inside {3'd2, 3'd3};
            end
            opc == INST_JAL: begin
                rd_used      = 1'b1;
                imm          = imm_j;
                ctrl.jump    = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = ALU_SRC_FOR_PC;
            end
            opc == INST_JALR: begin
                rs1_used     = 1'b1;
                rd_used      = 1'b1;
                imm          = imm_i;
                ctrl.jalr    = 1'b1;
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = ALU_SRC_IMM;
                ctrl.illegal = f3 != 3'd0;
            end
            opc == INST_LUI: begin
                rd_used      = 1'b1;
                imm          = imm_u;
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = ALU_SRC_IMM;
            end
            opc == INST_AUIPC: begin
                rd_used      = 1'b1;
                imm          = imm_u;
                ctrl.alu_op  = ALU_ADD;
                ctrl.alu_src = ALU_SRC_IMM_PC;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        ctrl.rd      = rd_used  ? ir[11:7]  : '0;
        ctrl.rs1     = rs1_used ? ir[19:15] : '0;
        ctrl.rs2     = rs2_used ? ir[24:20] : '0;
        ctrl.reg_wen = rd_used && (ir[11:7] != 5'd0);
        // an illegal word carries no side effects and reads no registers
        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            imm          = '0;
            rs1_used     = 1'b0;
            rs2_used     = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_reg.sv
// Registered decode stage: valid/ready handshake, load-use interlock
// against EX and the output register around id_decode_comb.
import id_stage_reg_pkg::*;

module id_stage_reg #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_ir,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  flush,
    input  logic                  ex_load_valid,
    input  logic [REG_ADDR_W-1:0] ex_load_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic                  reg_wen,
    output logic [REG_ADDR_W-1:0] reg_w_addr,
    output logic [REG_ADDR_W-1:0] reg_r_addr1,
    output logic [REG_ADDR_W-1:0] reg_r_addr2,
    output logic [XLEN-1:0]       imm,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [ALU_SRC_W-1:0]  alu_src_sel,
    output logic [2:0]            branch_op,
    output logic                  jump,
    output logic                  jalr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [2:0]            mem_size,
    output logic                  illegal
);

    ctrl_t           dec;
    ctrl_t           q;
    logic [XLEN-1:0] dec_imm;
    logic            rs1_used;
    logic            rs2_used;
    logic            hazard;
    logic            accept;

    id_decode_comb #(.XLEN(XLEN)) u_dec (
        .ir       (in_ir),
        .ctrl     (dec),
        .imm      (dec_imm),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign hazard = HAZARD_EN && ex_load_valid && (ex_load_rd != '0) &&
                    ((rs1_used && ex_load_rd == REG_ADDR_W'(dec.rs1)) ||
                     (rs2_used && ex_load_rd == REG_ADDR_W'(dec.rs2)));

    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // fields only load on accept, so a held bundle never moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            imm       <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= dec;
            imm       <= dec_imm;
            out_pc    <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign reg_wen     = q.reg_wen;
    assign reg_w_addr  = REG_ADDR_W'(q.rd);
    assign reg_r_addr1 = REG_ADDR_W'(q.rs1);
    assign reg_r_addr2 = REG_ADDR_W'(q.rs2);
    assign alu_op      = q.alu_op;
    assign alu_src_sel = q.alu_src;
    assign branch_op   = q.branch_op;
    assign jump        = q.jump;
    assign jalr        = q.jalr;
    assign mem_rd      = q.mem_rd;
    assign mem_wr      = q.mem_wr;
    assign mem_size    = q.mem_size;
    assign illegal     = q.illegal;

endmodule
